data_mem_dump: RTL and testbench

Debug-path stage that reads a contiguous block of the data memory and streams it, byte by byte, to the UART transmitter. It drives the data memory's Rd/Addr inputs and consumes its Out_Data. Its Tx_Data/Tx_Start outputs feed the UART TX, which acknowledges each byte with Tx_Done. It is started by the debug unit once the processor halts.

---
 rtl/data_mem_dump.sv | 127 ++++++++++++
 tb/tb_data_mem_dump.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_dump.sv
// Streams a contiguous block of data memory to the UART transmitter, one byte
// per Tx_Start/Tx_Done handshake, MSB byte of each word first.
module data_mem_dump #(
   parameter int addr_bus  = 11,
   parameter int data_size = 16,
   parameter int dump_len  = 16
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 Start,
   input  logic [addr_bus-1:0]  Base_Addr,
   output logic                 Mem_Rd,
   output logic [addr_bus-1:0]  Mem_Addr,
   input  logic [data_size-1:0] Mem_Data,
   output logic [7:0]           Tx_Data,
   output logic                 Tx_Start,
   input  logic                 Tx_Done,
   output logic                 Busy,
   output logic                 Done
);

   localparam int BPW = data_size / 8;
   localparam int WW  = addr_bus + 1;
   localparam int BW  = $clog2(BPW + 1);
   localparam logic [WW-1:0] LEN   = WW'(dump_len);
   localparam logic [BW-1:0] BPW_V = BW'(BPW);

   typedef enum logic [2:0] {
      IDLE, READ, LATCH, SEND, WAIT, NEXT, FIN
   } state_t;

   state_t               state;
   logic [addr_bus-1:0]  addr;
   logic [WW-1:0]        words_left;
   logic [BW-1:0]        bytes_left;
   logic [data_size-1:0] shift;
   logic [data_size-1:0] shift_next;

   assign shift_next = shift << 8;

   // Outputs are registered: each transition loads the values the target state presents.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state      <= IDLE;
         addr       <= '0;
         words_left <= '0;
         bytes_left <= '0;
         shift      <= '0;
         Mem_Rd     <= 1'b0;
         Mem_Addr   <= '0;
         Tx_Data    <= '0;
         Tx_Start   <= 1'b0;
         Busy       <= 1'b0;
         Done       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               Busy <= 1'b0;
               Done <= 1'b0;
               if (Start) begin
                  addr       <= Base_Addr;
                  words_left <= LEN;
                  Mem_Rd     <= 1'b1;
                  Mem_Addr   <= Base_Addr;
                  Busy       <= 1'b1;
                  state      <= READ;
               end
            end
            READ: begin
               Mem_Rd <= 1'b0;
               state  <= LATCH;
            end
            // Memory data is valid in this cycle, one cycle after the read strobe.
            LATCH: begin
               shift      <= Mem_Data;
               bytes_left <= BPW_V;
               Tx_Data    <= Mem_Data[data_size-1 -: 8];
               Tx_Start   <= 1'b1;
               state      <= SEND;
            end
            SEND: begin
               Tx_Start <= 1'b0;
               state    <= WAIT;
            end
            WAIT: begin
               if (Tx_Done) begin
                  if (bytes_left > BW'(1)) begin
                     shift      <= shift_next;
                     bytes_left <= bytes_left - BW'(1);
                     Tx_Data    <= shift_next[data_size-1 -: 8];
                     Tx_Start   <= 1'b1;
                     state      <= SEND;
                  end else begin
                     state <= NEXT;
                  end
               end
            end
            // Address wraps naturally at the memory size.
            NEXT: begin
               addr       <= addr + addr_bus'(1);
               words_left <= words_left - WW'(1);
               if (words_left == WW'(1)) begin
                  Done  <= 1'b1;
                  state <= FIN;
               end else begin
                  Mem_Rd   <= 1'b1;
                  Mem_Addr <= addr + addr_bus'(1);
                  state    <= READ;
               end
            end
            FIN: begin
               Done  <= 1'b0;
               Busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               Mem_Rd   <= 1'b0;
               Tx_Start <= 1'b0;
               Busy     <= 1'b0;
               Done     <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_dump.sv
// Scoreboard bench for data_mem_dump: memory and UART models, expected bytes and
// read addresses queued per dump and popped as the DUT produces them.
module tb_data_mem_dump;

   localparam int AW  = 11;
   localparam int DW  = 16;
   localparam int LEN = 2;
   localparam int BPW = DW / 8;

   logic          Clk = 1'b0;
   logic          Reset;
   logic          Start;
   logic [AW-1:0] Base_Addr;
   logic          Mem_Rd;
   logic [AW-1:0] Mem_Addr;
   logic [DW-1:0] Mem_Data;
   logic [7:0]    Tx_Data;
   logic          Tx_Start;
   logic          Tx_Done;
   logic          Busy;
   logic          Done;

   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [7:0]    exp_bytes [$];
   logic [AW-1:0] exp_addrs [$];

   int vectors    = 0;
   int miscompares = 0;
   int tx_count   = 0;
   int done_count = 0;
   int uart_cnt   = 0;
   int uart_delay = 10;
   bit spur_pulse = 1'b0;
   bit spur_in_send = 1'b0;

   always #5 Clk = ~Clk;

   data_mem_dump #(.addr_bus(AW), .data_size(DW), .dump_len(LEN)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Base_Addr(Base_Addr),
      .Mem_Rd(Mem_Rd), .Mem_Addr(Mem_Addr), .Mem_Data(Mem_Data),
      .Tx_Data(Tx_Data), .Tx_Start(Tx_Start), .Tx_Done(Tx_Done),
      .Busy(Busy), .Done(Done)
   );

   // Synchronous-read data memory: data valid the cycle after Rd.
   always @(posedge Clk) if (Mem_Rd) Mem_Data <= mem[Mem_Addr];

   // UART model plus scoreboard, all evaluated on the falling edge.
   initial begin
      logic [7:0]    eb;
      logic [AW-1:0] ea;
      Tx_Done = 1'b0;
      forever begin
         @(negedge Clk);
         Tx_Done    = spur_pulse;
         spur_pulse = 1'b0;
         if (uart_cnt > 0) begin
            uart_cnt--;
            if (uart_cnt == 0) Tx_Done = 1'b1;
         end
         if (Reset) begin
            if (Tx_Start) begin
               tx_count++;
               vectors++;
               if (exp_bytes.size() == 0) begin
                  miscompares++;
                  $display("[TB] FAIL tx_byte unexpected Tx_Data=%02h", Tx_Data);
               end else begin
                  eb = exp_bytes.pop_front();
                  if (Tx_Data !== eb) begin
                     miscompares++;
                     $display("[TB] FAIL tx_byte got=%02h want=%02h", Tx_Data, eb);
                  end
               end
               uart_cnt = uart_delay;
               if (spur_in_send) begin
                  Tx_Done      = 1'b1;
                  spur_in_send = 1'b0;
               end
            end
            if (Mem_Rd) begin
               vectors++;
               if (exp_addrs.size() == 0) begin
                  miscompares++;
                  $display("[TB] FAIL mem_addr unexpected read at %03h", Mem_Addr);
               end else begin
                  ea = exp_addrs.pop_front();
                  if (Mem_Addr !== ea) begin
                     miscompares++;
                     $display("[TB] FAIL mem_addr got=%03h want=%03h", Mem_Addr, ea);
                  end
               end
            end
            if (Done) done_count++;
         end
      end
   end

   task automatic push_dump(input logic [AW-1:0] base);
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      for (int w = 0; w < LEN; w++) begin
         a = base + AW'(w);
         d = mem[a];
         exp_addrs.push_back(a);
         for (int b = BPW - 1; b >= 0; b--) exp_bytes.push_back(d[b*8 +: 8]);
      end
   endtask

   task automatic applyStimulus(input logic [AW-1:0] base);
      @(negedge Clk);
      Base_Addr = base;
      Start     = 1'b1;
      @(negedge Clk);
      Start     = 1'b0;
   endtask

   task automatic wait_done(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         @(negedge Clk);
         if (Done === 1'b1) seen = 1'b1;
      end
   endtask

   task automatic wait_tx_start(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge Clk);
         if (Tx_Start === 1'b1) seen = 1'b1;
      end
   endtask

   task automatic test_reset;
      Reset = 1'b0;
      repeat (2) @(negedge Clk);
      vectors++;
      if ({Mem_Rd, Mem_Addr, Tx_Data, Tx_Start, Busy, Done} !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs got rd=%b addr=%03h tx=%02h st=%b busy=%b done=%b want all 0",
                  Mem_Rd, Mem_Addr, Tx_Data, Tx_Start, Busy, Done);
      end
      Reset = 1'b1;
      @(negedge Clk);
      vectors++;
      if (Busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_idle_busy got=%b want=0", Busy);
      end
   endtask

   task automatic test_nominal;
      bit seen;
      int tx0 = tx_count;
      int d0  = done_count;
      mem[11'h005] = 16'h1234;
      mem[11'h006] = 16'hABCD;
      uart_delay = 10;
      push_dump(11'h005);
      applyStimulus(11'h005);
      wait_done(seen);
      vectors++;
      if (!seen) begin miscompares++; $display("[TB] FAIL nominal_done got=timeout want=pulse"); end
      vectors++;
      if (Busy !== 1'b1) begin miscompares++; $display("[TB] FAIL nominal_busy_fin got=%b want=1", Busy); end
      @(negedge Clk);
      vectors++;
      if (Busy !== 1'b0 || Done !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL nominal_busy_fall got busy=%b done=%b want 0 0", Busy, Done);
      end
      vectors++;
      if (tx_count - tx0 != 4) begin miscompares++; $display("[TB] FAIL nominal_tx_count got=%0d want=4", tx_count - tx0); end
      vectors++;
      if (done_count - d0 != 1) begin miscompares++; $display("[TB] FAIL nominal_done_count got=%0d want=1", done_count - d0); end
      vectors++;
      if (exp_bytes.size() + exp_addrs.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL nominal_leftover got=%0d want=0", exp_bytes.size() + exp_addrs.size());
      end
   endtask

   task automatic test_wrap;
      bit seen;
      int tx0 = tx_count;
      mem[11'h7FF] = 16'h0102;
      mem[11'h000] = 16'hFEDC;
      uart_delay = 1;
      push_dump(11'h7FF);
      applyStimulus(11'h7FF);
      wait_done(seen);
      @(negedge Clk);
      vectors++;
      if (!seen) begin miscompares++; $display("[TB] FAIL wrap_done got=timeout want=pulse"); end
      vectors++;
      if (tx_count - tx0 != 4) begin miscompares++; $display("[TB] FAIL wrap_tx_count got=%0d want=4", tx_count - tx0); end
      vectors++;
      if (exp_bytes.size() + exp_addrs.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL wrap_leftover got=%0d want=0", exp_bytes.size() + exp_addrs.size());
      end
   endtask

   task automatic test_start_during;
      bit seen;
      int tx0 = tx_count;
      mem[11'h010] = 16'hC0DE;
      mem[11'h011] = 16'h0BAD;
      mem[11'h020] = 16'h9999;
      uart_delay = 10;
      push_dump(11'h010);
      applyStimulus(11'h010);
      wait_tx_start(seen);
      vectors++;
      if (!seen) begin miscompares++; $display("[TB] FAIL busy_start_tx got=timeout want=Tx_Start"); end
      repeat (2) @(negedge Clk);
      Base_Addr = 11'h020;
      Start     = 1'b1;
      @(negedge Clk);
      Start     = 1'b0;
      vectors++;
      if (Busy !== 1'b1) begin miscompares++; $display("[TB] FAIL busy_start_busy got=%b want=1", Busy); end
      wait_done(seen);
      vectors++;
      if (!seen) begin miscompares++; $display("[TB] FAIL busy_start_done got=timeout want=pulse"); end
      repeat (5) @(negedge Clk);
      vectors++;
      if (Busy !== 1'b0) begin miscompares++; $display("[TB] FAIL busy_start_idle got=%b want=0", Busy); end
      vectors++;
      if (tx_count - tx0 != 4) begin miscompares++; $display("[TB] FAIL busy_start_tx_count got=%0d want=4", tx_count - tx0); end
      vectors++;
      if (exp_bytes.size() + exp_addrs.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL busy_start_leftover got=%0d want=0", exp_bytes.size() + exp_addrs.size());
      end
   endtask

   task automatic test_spurious;
      bit seen;
      int tx0 = tx_count;
      uart_delay = 3;
      @(negedge Clk);
      spur_pulse = 1'b1;
      repeat (3) @(negedge Clk);
      vectors++;
      if (Busy !== 1'b0 || tx_count != tx0) begin
         miscompares++;
         $display("[TB] FAIL spur_idle got busy=%b tx=%0d want busy=0 tx=0", Busy, tx_count - tx0);
      end
      mem[11'h040] = 16'h3C5A;
      mem[11'h041] = 16'h7E81;
      push_dump(11'h040);
      spur_in_send = 1'b1;
      applyStimulus(11'h040);
      wait_done(seen);
      @(negedge Clk);
      vectors++;
      if (!seen) begin miscompares++; $display("[TB] FAIL spur_done got=timeout want=pulse"); end
      vectors++;
      if (spur_in_send !== 1'b0) begin miscompares++; $display("[TB] FAIL spur_send_injected got=%b want=0", spur_in_send); end
      vectors++;
      if (tx_count - tx0 != 4) begin miscompares++; $display("[TB] FAIL spur_tx_count got=%0d want=4", tx_count - tx0); end
      vectors++;
      if (exp_bytes.size() + exp_addrs.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL spur_leftover got=%0d want=0", exp_bytes.size() + exp_addrs.size());
      end
   endtask

   task automatic test_reset_mid;
      bit seen;
      int tx0;
      int d0;
      mem[11'h050] = 16'hAAAA;
      mem[11'h051] = 16'h5555;
      uart_delay = 10;
      push_dump(11'h050);
      applyStimulus(11'h050);
      wait_tx_start(seen);
      vectors++;
      if (!seen) begin miscompares++; $display("[TB] FAIL rst_mid_tx got=timeout want=Tx_Start"); end
      repeat (2) @(negedge Clk);
      #2 Reset = 1'b0;
      #1;
      vectors++;
      if ({Mem_Rd, Mem_Addr, Tx_Data, Tx_Start, Busy, Done} !== '0) begin
         miscompares++;
         $display("[TB] FAIL rst_mid_outputs got rd=%b addr=%03h tx=%02h st=%b busy=%b done=%b want all 0",
                  Mem_Rd, Mem_Addr, Tx_Data, Tx_Start, Busy, Done);
      end
      exp_bytes.delete();
      exp_addrs.delete();
      uart_cnt = 0;
      d0 = done_count;
      repeat (2) @(negedge Clk);
      Reset = 1'b1;
      repeat (3) @(negedge Clk);
      tx0 = tx_count;
      mem[11'h060] = 16'h5678;
      mem[11'h061] = 16'h9ABC;
      push_dump(11'h060);
      applyStimulus(11'h060);
      wait_done(seen);
      @(negedge Clk);
      vectors++;
      if (!seen) begin miscompares++; $display("[TB] FAIL rst_mid_done got=timeout want=pulse"); end
      vectors++;
      if (done_count - d0 != 1) begin miscompares++; $display("[TB] FAIL rst_mid_done_count got=%0d want=1", done_count - d0); end
      vectors++;
      if (tx_count - tx0 != 4) begin miscompares++; $display("[TB] FAIL rst_mid_tx_count got=%0d want=4", tx_count - tx0); end
      vectors++;
      if (exp_bytes.size() + exp_addrs.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL rst_mid_leftover got=%0d want=0", exp_bytes.size() + exp_addrs.size());
      end
   endtask

   task automatic test_back_to_back;
      bit seen;
      int tx0 = tx_count;
      int d0  = done_count;
      mem[11'h070] = 16'h0F1E;
      mem[11'h071] = 16'h2D3C;
      mem[11'h072] = 16'h4B5A;
      mem[11'h073] = 16'h6978;
      uart_delay = 1;
      push_dump(11'h070);
      push_dump(11'h072);
      applyStimulus(11'h070);
      wait_done(seen);
      vectors++;
      if (!seen) begin miscompares++; $display("[TB] FAIL b2b_first_done got=timeout want=pulse"); end
      Base_Addr = 11'h072;
      @(negedge Clk);
      vectors++;
      if (Busy !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_gap_busy got=%b want=0", Busy); end
      Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      vectors++;
      if (Busy !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_accept got=%b want=1", Busy); end
      wait_done(seen);
      @(negedge Clk);
      vectors++;
      if (!seen) begin miscompares++; $display("[TB] FAIL b2b_second_done got=timeout want=pulse"); end
      vectors++;
      if (done_count - d0 != 2) begin miscompares++; $display("[TB] FAIL b2b_done_count got=%0d want=2", done_count - d0); end
      vectors++;
      if (tx_count - tx0 != 8) begin miscompares++; $display("[TB] FAIL b2b_tx_count got=%0d want=8", tx_count - tx0); end
      vectors++;
      if (exp_bytes.size() + exp_addrs.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL b2b_leftover got=%0d want=0", exp_bytes.size() + exp_addrs.size());
      end
   endtask

   initial begin
      Reset     = 1'b0;
      Start     = 1'b0;
      Base_Addr = '0;
      test_reset;
      test_nominal;
      test_wrap;
      test_start_during;
      test_spurious;
      test_reset_mid;
      test_back_to_back;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
